// File: rtl/hmmm_mc_pkg.sv
// Shared opcode, state and instruction-field definitions for the multi-cycle HMMM core.
package hmmm_mc_pkg;

    typedef enum logic [3:0] {
        F_NOP   = 4'h0,
        F_SETN  = 4'h1,
        F_STORE = 4'h2,
        F_LOAD  = 4'h3,
        F_ADDN  = 4'h4,
        F_COPY  = 4'h5,
        F_ADD   = 4'h6,
        F_SUB   = 4'h7,
        F_JEQZN = 4'h8,
        F_JNEZN = 4'h9,
        F_JGTZN = 4'hA,
        F_JLTZN = 4'hB,
        F_JUMPN = 4'hC,
        F_JUMPR = 4'hD,
        F_CALLN = 4'hE,
        F_HALT  = 4'hF
    } funct_e;

    typedef logic [1:0] state_e;

    localparam state_e FETCH = 2'd0;
    localparam state_e EXEC  = 2'd1;
    localparam state_e MEM   = 2'd2;
    localparam state_e HALT  = 2'd3;

    localparam int FIELD_W   = 4;
    localparam int IMM_W     = 8;
    localparam int FUNCT_LSB = 12;
    localparam int RD_LSB    = 8;
    localparam int RA_LSB    = 4;
    localparam int RB_LSB    = 0;
    localparam int IMM_LSB   = 0;

endpackage

// File: rtl/hmmm_regfile_mc.sv
// Register file: two combinational read ports, one write port clocked on ph2.
// r0 is never written and always reads zero; reset clears every entry synchronously.
module hmmm_regfile_mc #(
    parameter int NREGS  = 8,
    parameter int DATA_W = 8,
    parameter int IW     = $clog2(NREGS)
) (
    input  logic              ph2,
    input  logic              reset,
    input  logic              we,
    input  logic [IW-1:0]     waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [IW-1:0]     raddr_a,
    output logic [DATA_W-1:0] rdata_a,
    input  logic [IW-1:0]     raddr_b,
    output logic [DATA_W-1:0] rdata_b
);

    logic [DATA_W-1:0] regs_q [NREGS];
    logic [DATA_W-1:0] regs_d [NREGS];

    always_comb begin
        regs_d = regs_q;
        if (reset) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_d[i] = '0;
            end
        end else if (we && (waddr != '0)) begin
            regs_d[waddr] = wdata;
        end
    end

    always_ff @(posedge ph2) begin
        regs_q <= regs_d;
    end

    assign rdata_a = (raddr_a == '0) ? '0 : regs_q[raddr_a];
    assign rdata_b = (raddr_b == '0) ? '0 : regs_q[raddr_b];

endmodule

// File: rtl/hmmm_core_mc.sv
// Multi-cycle HMMM core: FETCH/EXEC/MEM/HALT sequencer with req/ready instruction and data ports.
// Next-state values and reset are captured on ph2 and committed on ph1; register writes land on ph2.
module hmmm_core_mc
    import hmmm_mc_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 8,
    parameter int NREGS  = 8
) (
    input  logic              ph1,
    input  logic              ph2,
    input  logic              reset,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [15:0]       imem_rdata,
    input  logic              imem_ready,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [ADDR_W-1:0] dmem_addr,
    output logic [DATA_W-1:0] dmem_wdata,
    input  logic [DATA_W-1:0] dmem_rdata,
    input  logic              dmem_ready,
    output logic              halted,
    output logic [ADDR_W-1:0] pc_dbg
);

    localparam int IW = $clog2(NREGS);

    state_e            state_q, state_s_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_s_q, pc_d;
    logic [15:0]       ir_q, ir_s_q, ir_d;
    logic              rst_s_q;

    funct_e             funct;
    logic [FIELD_W-1:0] rd_f, ra_f, rb_f;
    logic [IMM_W-1:0]   imm_f;
    logic signed [IMM_W-1:0] imm_s;
    logic [IW-1:0]      rd_idx, ra_idx, rb_idx, raddr_a;
    logic [DATA_W-1:0]  rdata_a, rdata_b, imm_data, link_data, rf_wdata;
    logic [ADDR_W-1:0]  imm_addr, pc_inc;
    logic               rf_we, use_ra, rd_zero, rd_neg, fetch_done, mem_done;

    assign funct  = funct_e'(ir_q[FUNCT_LSB +: FIELD_W]);
    assign rd_f   = ir_q[RD_LSB +: FIELD_W];
    assign ra_f   = ir_q[RA_LSB +: FIELD_W];
    assign rb_f   = ir_q[RB_LSB +: FIELD_W];
    assign imm_f  = ir_q[IMM_LSB +: IMM_W];
    assign rd_idx = IW'(rd_f);
    assign ra_idx = IW'(ra_f);
    assign rb_idx = IW'(rb_f);

    assign imm_s     = imm_f;
    assign imm_data  = DATA_W'(imm_s);
    assign imm_addr  = ADDR_W'(imm_f);
    assign pc_inc    = pc_q + ADDR_W'(1);
    assign link_data = DATA_W'(pc_inc);

    // Port A carries ra for the two-source ops and rd for everything else.
    assign use_ra  = (funct == F_COPY) || (funct == F_ADD) || (funct == F_SUB);
    assign raddr_a = use_ra ? ra_idx : rd_idx;
    assign rd_zero = (rdata_a == '0);
    assign rd_neg  = rdata_a[DATA_W-1];

    hmmm_regfile_mc #(
        .NREGS  (NREGS),
        .DATA_W (DATA_W),
        .IW     (IW)
    ) u_rf (
        .ph2     (ph2),
        .reset   (reset),
        .we      (rf_we & ~reset),
        .waddr   (rd_idx),
        .wdata   (rf_wdata),
        .raddr_a (raddr_a),
        .rdata_a (rdata_a),
        .raddr_b (rb_idx),
        .rdata_b (rdata_b)
    );

    assign imem_req   = (state_q == FETCH) && !reset;
    assign imem_addr  = pc_q;
    assign dmem_req   = (state_q == MEM) && !reset;
    assign dmem_we    = dmem_req && (funct == F_STORE);
    assign dmem_addr  = rdata_b[ADDR_W-1:0];
    assign dmem_wdata = rdata_a;
    assign halted     = (state_q == HALT) && !reset;
    assign pc_dbg     = pc_q;

    // Ready only counts while the matching request is up, so reset aborts cleanly.
    assign fetch_done = imem_req && imem_ready;
    assign mem_done   = dmem_req && dmem_ready;

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        ir_d     = ir_q;
        rf_we    = 1'b0;
        rf_wdata = '0;
        case (state_q)
            FETCH: begin
                if (fetch_done) begin
                    ir_d    = imem_rdata;
                    state_d = EXEC;
                end
            end
            EXEC: begin
                state_d = FETCH;
                pc_d    = pc_inc;
                case (funct)
                    F_NOP:   ;
                    F_SETN:  begin rf_we = 1'b1; rf_wdata = imm_data; end
                    F_ADDN:  begin rf_we = 1'b1; rf_wdata = rdata_a + imm_data; end
                    F_COPY:  begin rf_we = 1'b1; rf_wdata = rdata_a; end
                    F_ADD:   begin rf_we = 1'b1; rf_wdata = rdata_a + rdata_b; end
                    F_SUB:   begin rf_we = 1'b1; rf_wdata = rdata_a - rdata_b; end
                    F_JEQZN: if (rd_zero) pc_d = imm_addr;
                    F_JNEZN: if (!rd_zero) pc_d = imm_addr;
                    F_JGTZN: if (!rd_zero && !rd_neg) pc_d = imm_addr;
                    F_JLTZN: if (rd_neg) pc_d = imm_addr;
                    F_JUMPN: pc_d = imm_addr;
                    F_JUMPR: pc_d = rdata_a[ADDR_W-1:0];
                    F_CALLN: begin
                        rf_we    = 1'b1;
                        rf_wdata = link_data;
                        pc_d     = imm_addr;
                    end
                    F_STORE, F_LOAD: begin
                        state_d = MEM;
                        pc_d    = pc_q;
                    end
                    F_HALT: begin
                        state_d = HALT;
                        pc_d    = pc_q;
                    end
                    default: ;
                endcase
            end
            MEM: begin
                if (mem_done) begin
                    if (funct == F_LOAD) begin
                        rf_we    = 1'b1;
                        rf_wdata = dmem_rdata;
                    end
                    pc_d    = pc_inc;
                    state_d = FETCH;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge ph2) begin
        rst_s_q   <= reset;
        state_s_q <= state_d;
        pc_s_q    <= pc_d;
        ir_s_q    <= ir_d;
    end

    always_ff @(posedge ph1) begin
        if (rst_s_q) begin
            state_q <= FETCH;
            pc_q    <= '0;
            ir_q    <= '0;
        end else begin
            state_q <= state_s_q;
            pc_q    <= pc_s_q;
            ir_q    <= ir_s_q;
        end
    end

endmodule

// File: tb/tb_hmmm_core_mc.sv
// Directed bench for hmmm_core_mc: an 8-bit/8-register instance and a 16-bit/16-register instance.
module tb_hmmm_core_mc;

    logic ph1, ph2;
    logic rst8, rst16;

    logic        imem_req8, imem_ready8, dmem_req8, dmem_we8, dmem_ready8, halted8;
    logic [7:0]  imem_addr8, dmem_addr8, dmem_wdata8, dmem_rdata8, pc8;
    logic [15:0] imem_rdata8;

    logic        imem_req16, imem_ready16, dmem_req16, dmem_we16, dmem_ready16, halted16;
    logic [7:0]  imem_addr16, dmem_addr16, pc16;
    logic [15:0] imem_rdata16, dmem_wdata16, dmem_rdata16;

    logic [15:0] imem8  [256];
    logic [15:0] imem16 [256];

    int checks = 0;
    int errors = 0;

    assign imem_rdata8  = imem8[imem_addr8];
    assign imem_rdata16 = imem16[imem_addr16];

    hmmm_core_mc #(.DATA_W(8), .ADDR_W(8), .NREGS(8)) u8 (
        .ph1(ph1), .ph2(ph2), .reset(rst8),
        .imem_req(imem_req8), .imem_addr(imem_addr8), .imem_rdata(imem_rdata8), .imem_ready(imem_ready8),
        .dmem_req(dmem_req8), .dmem_we(dmem_we8), .dmem_addr(dmem_addr8), .dmem_wdata(dmem_wdata8),
        .dmem_rdata(dmem_rdata8), .dmem_ready(dmem_ready8), .halted(halted8), .pc_dbg(pc8)
    );

    hmmm_core_mc #(.DATA_W(16), .ADDR_W(8), .NREGS(16)) u16 (
        .ph1(ph1), .ph2(ph2), .reset(rst16),
        .imem_req(imem_req16), .imem_addr(imem_addr16), .imem_rdata(imem_rdata16), .imem_ready(imem_ready16),
        .dmem_req(dmem_req16), .dmem_we(dmem_we16), .dmem_addr(dmem_addr16), .dmem_wdata(dmem_wdata16),
        .dmem_rdata(dmem_rdata16), .dmem_ready(dmem_ready16), .halted(halted16), .pc_dbg(pc16)
    );

    // Non-overlapping phases: ph1 rises at 10n+1, ph2 rises at 10n+5.
    initial begin
        ph1 = 1'b0;
        ph2 = 1'b0;
        forever begin
            #1 ph1 = 1'b1;
            #3 ph1 = 1'b0;
            #1 ph2 = 1'b1;
            #3 ph2 = 1'b0;
            #2;
        end
    end

    initial begin
        #50000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge ph1);
            #2;
        end
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        rst8 = 1'b1;  rst16 = 1'b1;
        imem_ready8 = 1'b1;  dmem_ready8 = 1'b1;  dmem_rdata8 = 8'h00;
        imem_ready16 = 1'b1; dmem_ready16 = 1'b1; dmem_rdata16 = 16'h0000;
        for (int i = 0; i < 256; i++) begin
            imem8[i]  = 16'h0000;
            imem16[i] = 16'h0000;
        end
        imem8[8'h00] = 16'h11FD; imem8[8'h01] = 16'h2100; imem8[8'h02] = 16'h117F;
        imem8[8'h03] = 16'h1201; imem8[8'h04] = 16'h6312; imem8[8'h05] = 16'h7421;
        imem8[8'h06] = 16'h1005; imem8[8'h07] = 16'h3502; imem8[8'h08] = 16'hB320;
        imem8[8'h20] = 16'h8320; imem8[8'h21] = 16'hC010; imem8[8'h10] = 16'hE540;
        imem8[8'h40] = 16'hD500; imem8[8'h11] = 16'hC0FF; imem8[8'hFF] = 16'h0000;
        imem16[8'h00] = 16'h1FFF; imem16[8'h01] = 16'h1101; imem16[8'h02] = 16'h3200;
        imem16[8'h03] = 16'h6321; imem16[8'h04] = 16'hBF30; imem16[8'h30] = 16'hA250;
        imem16[8'h50] = 16'hF000;

        // ---- 8-bit core: reset state ----
        cyc(3);
        chk("rst_pc", 16'(pc8), 16'h0000);
        chk("rst_imem_req", 16'(imem_req8), 16'h0000);
        chk("rst_dmem_req", 16'(dmem_req8), 16'h0000);
        chk("rst_halted", 16'(halted8), 16'h0000);
        chk("rst_r1", 16'(u8.u_rf.regs_q[1]), 16'h0000);

        rst8 = 1'b0; #1;
        chk("fetch0_req", 16'(imem_req8), 16'h0001);
        chk("fetch0_addr", 16'(imem_addr8), 16'h0000);
        cyc(1);
        chk("exec0_no_req", 16'(imem_req8), 16'h0000);
        cyc(1);
        chk("setn_r1", 16'(u8.u_rf.regs_q[1]), 16'h00FD);
        chk("setn_pc", 16'(pc8), 16'h0001);
        chk("fetch1_addr", 16'(imem_addr8), 16'h0001);
        cyc(2);
        chk("store_req", 16'(dmem_req8), 16'h0001);
        chk("store_we", 16'(dmem_we8), 16'h0001);
        chk("store_addr", 16'(dmem_addr8), 16'h0000);
        chk("store_wdata", 16'(dmem_wdata8), 16'h00FD);
        cyc(1);
        chk("store_pc", 16'(pc8), 16'h0002);
        chk("store_req_drop", 16'(dmem_req8), 16'h0000);

        // ---- ALU ----
        cyc(6);
        chk("setn_r1_7f", 16'(u8.u_rf.regs_q[1]), 16'h007F);
        chk("setn_r2_01", 16'(u8.u_rf.regs_q[2]), 16'h0001);
        chk("add_r3", 16'(u8.u_rf.regs_q[3]), 16'h0080);
        cyc(2);
        chk("sub_r4", 16'(u8.u_rf.regs_q[4]), 16'h0082);
        cyc(2);
        chk("r0_zero", 16'(u8.u_rf.regs_q[0]), 16'h0000);
        chk("pc_before_load", 16'(pc8), 16'h0007);

        // ---- load with three wait states ----
        dmem_ready8 = 1'b0;
        dmem_rdata8 = 8'h5A;
        cyc(1);
        for (int i = 0; i < 3; i++) begin
            cyc(1);
            chk("load_wait_req", 16'(dmem_req8), 16'h0001);
            chk("load_wait_addr", 16'(dmem_addr8), 16'h0001);
            chk("load_wait_we", 16'(dmem_we8), 16'h0000);
            chk("load_wait_pc", 16'(pc8), 16'h0007);
        end
        cyc(1);
        dmem_ready8 = 1'b1; #1;
        chk("load_rdy_req", 16'(dmem_req8), 16'h0001);
        chk("load_rdy_addr", 16'(dmem_addr8), 16'h0001);
        cyc(1);
        chk("load_r5", 16'(u8.u_rf.regs_q[5]), 16'h005A);
        chk("load_pc", 16'(pc8), 16'h0008);
        chk("load_req_drop", 16'(dmem_req8), 16'h0000);
        chk("load_next_fetch", 16'(imem_req8), 16'h0001);

        // ---- branches, call, jump register, PC wrap ----
        cyc(2);
        chk("jltzn_taken", 16'(pc8), 16'h0020);
        cyc(2);
        chk("jeqzn_not_taken", 16'(pc8), 16'h0021);
        cyc(2);
        chk("jumpn", 16'(pc8), 16'h0010);
        cyc(2);
        chk("calln_pc", 16'(pc8), 16'h0040);
        chk("calln_link", 16'(u8.u_rf.regs_q[5]), 16'h0011);
        cyc(2);
        chk("jumpr", 16'(pc8), 16'h0011);
        cyc(2);
        chk("jump_ff", 16'(pc8), 16'h00FF);
        cyc(2);
        chk("nop_wrap", 16'(pc8), 16'h0000);

        // ---- reset during a store ----
        cyc(4);
        chk("abort_pre_req", 16'(dmem_req8), 16'h0001);
        rst8 = 1'b1; #1;
        chk("abort_req_drop", 16'(dmem_req8), 16'h0000);
        chk("abort_we_drop", 16'(dmem_we8), 16'h0000);
        cyc(1);
        chk("abort_pc", 16'(pc8), 16'h0000);
        chk("abort_r1", 16'(u8.u_rf.regs_q[1]), 16'h0000);
        chk("abort_r5", 16'(u8.u_rf.regs_q[5]), 16'h0000);

        // ---- halt ----
        imem8[8'h00] = 16'hF000;
        rst8 = 1'b0; #1;
        chk("halt_fetch_req", 16'(imem_req8), 16'h0001);
        cyc(2);
        chk("halted", 16'(halted8), 16'h0001);
        for (int i = 0; i < 3; i++) begin
            cyc(1);
            chk("halt_no_fetch", 16'(imem_req8), 16'h0000);
            chk("halt_no_dmem", 16'(dmem_req8), 16'h0000);
            chk("halt_hold", 16'(halted8), 16'h0001);
        end
        rst8 = 1'b1; #1;
        chk("halt_reset_clear", 16'(halted8), 16'h0000);

        // ---- 16-bit / 16-register core ----
        cyc(1);
        chk("w16_rst_pc", 16'(pc16), 16'h0000);
        chk("w16_rst_req", 16'(imem_req16), 16'h0000);
        rst16 = 1'b0;
        dmem_rdata16 = 16'h7FFF; #1;
        chk("w16_fetch0", 16'(imem_req16), 16'h0001);
        cyc(2);
        chk("w16_r15", u16.u_rf.regs_q[15], 16'hFFFF);
        cyc(2);
        chk("w16_r1", u16.u_rf.regs_q[1], 16'h0001);
        cyc(2);
        chk("w16_load_req", 16'(dmem_req16), 16'h0001);
        chk("w16_load_addr", 16'(dmem_addr16), 16'h0000);
        chk("w16_load_we", 16'(dmem_we16), 16'h0000);
        cyc(1);
        chk("w16_r2", u16.u_rf.regs_q[2], 16'h7FFF);
        chk("w16_load_pc", 16'(pc16), 16'h0003);
        cyc(2);
        chk("w16_add_r3", u16.u_rf.regs_q[3], 16'h8000);
        cyc(2);
        chk("w16_jltzn", 16'(pc16), 16'h0030);
        cyc(2);
        chk("w16_jgtzn", 16'(pc16), 16'h0050);
        cyc(2);
        chk("w16_halted", 16'(halted16), 16'h0001);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
